mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 25, byte address width; TIMEOUT, default 255, maximum downstream cycles per access before abort.
REQ-002 Ports SHALL be:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  instruction fetch request, level.
- i_addr  in  ADDR_W  fetch address.
- i_valid  out  1  fetch complete, one-cycle pulse.
- i_rdata  out  32  fetched word.
- d_enable  in  1  data request, level.
- d_rw  in  1  0 read, 1 write.
- d_oplen  in  2  0 byte, 1 half, 2 word.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  32  write data.
- d_valid  out  1  data access complete, one-cycle pulse.
- d_rdata  out  32  read data.
- m_enable  out  1  downstream request, level.
- m_rw, m_oplen, m_addr, m_wdata  out  1/2/ADDR_W/32  downstream command fields.
- m_done  in  1  downstream completion, one-cycle pulse.
- m_rdata  in  32  downstream read data, valid with m_done.
- err_timeout  out  1  sticky timeout flag.

Function
REQ-003 FSM states SHALL be IDLE, GRANT_I, GRANT_D; one grant at a time.
REQ-004 In IDLE, a sampled request SHALL move the FSM to its grant state at the next edge; m_enable and the command fields are registered there and held constant until grant ends.
REQ-005 Instruction grants SHALL drive m_rw=0 and m_oplen=2.
REQ-006 In a grant, m_done SHALL return the FSM to IDLE and pulse the owner's valid for exactly one cycle at the next edge, with its rdata registered from m_rdata.
REQ-007 i_rdata and d_rdata SHALL hold their last value until the next completion for that requester.
REQ-008 A requester SHALL keep its enable high until its valid; enable dropping mid-grant SHALL NOT abort the access.
REQ-009 After a valid pulse the FSM SHALL spend at least one cycle in IDLE before re-granting, so that pulse is never seen as a new request.
REQ-010 Minimum latency SHALL be: request at edge N, m_enable at N+1, m_done at N+k, valid pulse at N+k+1.
REQ-011 An 8-bit wait counter SHALL clear on grant entry and increment each grant cycle without m_done.
REQ-012 Reaching TIMEOUT SHALL drop m_enable, set err_timeout, pulse the owner's valid with rdata = 32'hDEAD_BEEF, and return to IDLE.
REQ-013 m_done arriving in IDLE SHALL be ignored.
REQ-014 Simultaneous requests in IDLE SHALL resolve per REQ-017.

Reset
REQ-015 On rst_n low, immediately and asynchronously: FSM=IDLE; m_enable, i_valid, d_valid, err_timeout=0; i_rdata, d_rdata, m_addr, m_wdata=0; m_rw=0; m_oplen=0; wait counter=0; RR pointer=instruction.
REQ-016 Reset mid-grant SHALL abandon the access with no valid pulse; err_timeout clears only by reset.

Configuration
REQ-017 With MEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester not served last (pointer updates on each completion); undefined, the data port SHALL always win.

Verification
REQ-018 Bench SHALL cover:
- i_enable=1, i_addr=0x100, m_done after 3 cycles with m_rdata=0x00000013 -> m_addr=0x100, m_rw=0, m_oplen=2, one i_valid pulse, i_rdata=0x13.
- d_enable=1, d_rw=1, d_addr=0x2004, d_wdata=0xCAFEF00D, d_oplen=0 -> m command fields match and are held stable, d_valid single pulse, d_rdata unchanged.
- Both requests held for 4 accesses -> macro defined: grants D,I,D,I (pointer starts at instruction); undefined: D,D,D,D while d_enable held.
- No m_done -> m_enable drops after 255 grant cycles, err_timeout=1, valid pulse with rdata 0xDEADBEEF.
- rst_n low during GRANT_D -> outputs at reset values same cycle, no d_valid, next request granted normally.
- Stray m_done in IDLE -> no valid pulses, FSM stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one downstream memory port with timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise data wins.
module mem_port_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_enable,
  input  logic              d_rw,
  input  logic [1:0]        d_oplen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              m_enable,
  output logic              m_rw,
  output logic [1:0]        m_oplen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_done,
  input  logic [31:0]       m_rdata,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        d_wins;
  logic        pick_d;
  logic        pick_i;
  logic        timed_out;
  logic        finish;
  logic [31:0] fin_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;

  // last_d records who completed most recently; the other side wins ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (finish) begin
      last_d <= (state == GRANT_D);
    end
  end

  assign d_wins = !last_d;
`else
  assign d_wins = 1'b1;
`endif

  assign pick_d    = d_enable && (!i_enable || d_wins);
  assign pick_i    = i_enable && !pick_d;
  assign timed_out = (wait_cnt == TO_LAST);
  assign finish    = (state != IDLE) && (m_done || timed_out);
  assign fin_data  = m_done ? m_rdata : 32'hDEAD_BEEF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      i_valid     <= 1'b0;
      d_valid     <= 1'b0;
      i_rdata     <= 32'd0;
      d_rdata     <= 32'd0;
      m_enable    <= 1'b0;
      m_rw        <= 1'b0;
      m_oplen     <= 2'd0;
      m_addr      <= '0;
      m_wdata     <= 32'd0;
      err_timeout <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          // a valid pulse still on the wires blocks re-grant for one cycle
          if (!i_valid && !d_valid) begin
            if (pick_d) begin
              state    <= GRANT_D;
              wait_cnt <= 8'd0;
              m_enable <= 1'b1;
              m_rw     <= d_rw;
              m_oplen  <= d_oplen;
              m_addr   <= d_addr;
              m_wdata  <= d_wdata;
            end else if (pick_i) begin
              state    <= GRANT_I;
              wait_cnt <= 8'd0;
              m_enable <= 1'b1;
              m_rw     <= 1'b0;
              m_oplen  <= 2'd2;
              m_addr   <= i_addr;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (finish) begin
            state    <= IDLE;
            m_enable <= 1'b0;
            if (!m_done) begin
              err_timeout <= 1'b1;
            end
            if (state == GRANT_I) begin
              i_valid <= 1'b1;
              i_rdata <= fin_data;
            end else begin
              d_valid <= 1'b1;
              if (!m_rw || !m_done) begin
                d_rdata <= fin_data;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, write, read, ties,
// timeout, async reset mid-grant and stray completion.
module tb_mem_port_arbiter;

  localparam int AW = 25;

  logic          clk;
  logic          rst_n;
  logic          i_enable;
  logic [AW-1:0] i_addr;
  logic          i_valid;
  logic [31:0]   i_rdata;
  logic          d_enable;
  logic          d_rw;
  logic [1:0]    d_oplen;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_valid;
  logic [31:0]   d_rdata;
  logic          m_enable;
  logic          m_rw;
  logic [1:0]    m_oplen;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic          m_done;
  logic [31:0]   m_rdata;
  logic          err_timeout;

  int errors = 0;
  int checks = 0;
  int i_pulses = 0;
  int d_pulses = 0;

  mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_enable(i_enable), .i_addr(i_addr),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_enable(d_enable), .d_rw(d_rw), .d_oplen(d_oplen),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .m_enable(m_enable), .m_rw(m_rw), .m_oplen(m_oplen),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i_valid) i_pulses++;
    if (d_valid) d_pulses++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_enable) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  // returns at the negedge right after m_done was sampled
  task automatic finish_access(input int dly, input logic [31:0] rd);
    repeat (dly) @(negedge clk);
    m_done  = 1'b1;
    m_rdata = rd;
    @(negedge clk);
    m_done  = 1'b0;
    m_rdata = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int p0;
    int cnt;
    bit exp_d;
    rst_n    = 1'b0;
    i_enable = 1'b0;
    i_addr   = '0;
    d_enable = 1'b0;
    d_rw     = 1'b0;
    d_oplen  = 2'd0;
    d_addr   = '0;
    d_wdata  = 32'd0;
    m_done   = 1'b0;
    m_rdata  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_m_enable", 32'(m_enable), 32'd0);
    check("rst_valids", {30'd0, i_valid, d_valid}, 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_oplen", 32'(m_oplen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // instruction fetch
    p0 = i_pulses;
    i_enable = 1'b1;
    i_addr   = 25'h100;
    wait_grant("fetch_grant");
    check("fetch_m_addr", 32'(m_addr), 32'h100);
    check("fetch_m_rw", 32'(m_rw), 32'd0);
    check("fetch_m_oplen", 32'(m_oplen), 32'd2);
    i_enable = 1'b0;
    finish_access(2, 32'h0000_0013);
    check("fetch_i_valid", 32'(i_valid), 32'd1);
    check("fetch_i_rdata", i_rdata, 32'h13);
    check("fetch_m_enable_off", 32'(m_enable), 32'd0);
    @(negedge clk);
    check("fetch_pulse_once", 32'(i_pulses - p0), 32'd1);
    check("fetch_d_valid", 32'(d_pulses), 32'd0);

    // byte write
    p0 = d_pulses;
    d_enable = 1'b1;
    d_rw     = 1'b1;
    d_addr   = 25'h2004;
    d_wdata  = 32'hCAFE_F00D;
    d_oplen  = 2'd0;
    wait_grant("wr_grant");
    check("wr_m_rw", 32'(m_rw), 32'd1);
    check("wr_m_oplen", 32'(m_oplen), 32'd0);
    check("wr_m_addr", 32'(m_addr), 32'h2004);
    check("wr_m_wdata", m_wdata, 32'hCAFE_F00D);
    d_addr  = 25'h777;
    d_wdata = 32'h0;
    d_rw    = 1'b0;
    repeat (2) @(negedge clk);
    check("wr_hold_addr", 32'(m_addr), 32'h2004);
    check("wr_hold_wdata", m_wdata, 32'hCAFE_F00D);
    check("wr_hold_rw", 32'(m_rw), 32'd1);
    d_enable = 1'b0;
    finish_access(0, 32'h1234_5678);
    check("wr_d_valid", 32'(d_valid), 32'd1);
    check("wr_d_rdata_kept", d_rdata, 32'd0);
    @(negedge clk);
    check("wr_pulse_once", 32'(d_pulses - p0), 32'd1);

    // word read
    d_enable = 1'b1;
    d_rw     = 1'b0;
    d_oplen  = 2'd2;
    d_addr   = 25'h40;
    wait_grant("rd_grant");
    d_enable = 1'b0;
    finish_access(1, 32'hA5A5_0001);
    check("rd_d_rdata", d_rdata, 32'hA5A5_0001);
    check("rd_i_rdata_held", i_rdata, 32'h13);

    // simultaneous requests, pointer fresh from reset
    do_reset();
    i_enable = 1'b1;
    i_addr   = 25'h100;
    d_enable = 1'b1;
    d_addr   = 25'h2004;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      wait_grant($sformatf("arb_grant%0d", k));
      check($sformatf("arb_owner%0d", k),
            32'(m_addr == 25'h2004), 32'(exp_d));
      finish_access(1, 32'(k));
    end
    i_enable = 1'b0;
    d_enable = 1'b0;
    repeat (2) @(negedge clk);

    // timeout on a fetch
    i_enable = 1'b1;
    i_addr   = 25'h300;
    wait_grant("to_grant");
    cnt = 1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!m_enable) break;
      cnt++;
    end
    i_enable = 1'b0;
    check("to_cycles", 32'(cnt), 32'd255);
    check("to_err", 32'(err_timeout), 32'd1);
    check("to_i_valid", 32'(i_valid), 32'd1);
    check("to_i_rdata", i_rdata, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    check("to_err_sticky", 32'(err_timeout), 32'd1);

    // async reset in the middle of a data grant
    p0 = d_pulses;
    d_enable = 1'b1;
    d_rw     = 1'b0;
    d_addr   = 25'h50;
    wait_grant("rst_grant");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_m_enable", 32'(m_enable), 32'd0);
    check("midrst_err", 32'(err_timeout), 32'd0);
    check("midrst_m_addr", 32'(m_addr), 32'd0);
    check("midrst_i_rdata", i_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant("after_rst_grant");
    check("after_rst_addr", 32'(m_addr), 32'h50);
    d_enable = 1'b0;
    finish_access(1, 32'h0BAD_CAFE);
    check("after_rst_d_rdata", d_rdata, 32'h0BAD_CAFE);
    @(negedge clk);
    check("midrst_pulses", 32'(d_pulses - p0), 32'd1);

    // stray completion while idle
    p0 = i_pulses + d_pulses;
    finish_access(1, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    check("stray_pulses", 32'(i_pulses + d_pulses - p0), 32'd0);
    check("stray_m_enable", 32'(m_enable), 32'd0);
    check("stray_d_rdata", d_rdata, 32'h0BAD_CAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
